// File: rtl/mmio_bus_if.sv
// CPU-side bus of the memory-mapped I/O decoder: word address, write data,
// write strobe and combinational read data.
interface mmio_bus_if;
    logic [15:0] addr;
    logic [15:0] din;
    logic        we;
    logic [15:0] dout;

    modport master (output addr, din, we, input dout);
    modport slave  (input addr, din, we, output dout);
endinterface

// File: rtl/mmio_bus.sv
// Memory-mapped I/O decoder: lower 32K words pass through to external RAM,
// upper half holds GPIO port pairs, edge-change flags and a down-counting timer.
module mmio_bus #(
    parameter int IO_WIDTH  = 4,
    parameter int NUM_PORTS = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    mmio_bus_if.slave                     bus,
    output logic [14:0]                   ram_addr,
    output logic [15:0]                   ram_din,
    output logic                          ram_we,
    input  logic [15:0]                   ram_dout,
    input  logic [NUM_PORTS*IO_WIDTH-1:0] io_in,
    output logic [NUM_PORTS*IO_WIDTH-1:0] io_out,
    output logic                          irq
);
    localparam int PW = NUM_PORTS * IO_WIDTH;

    localparam logic [2:0] R_EDGE_FLAGS = 3'd0;
    localparam logic [2:0] R_EDGE_MASK  = 3'd1;
    localparam logic [2:0] R_CTRL       = 3'd2;
    localparam logic [2:0] R_COUNT      = 3'd3;
    localparam logic [2:0] R_RELOAD     = 3'd4;
    localparam logic [2:0] R_STATUS     = 3'd5;

    logic                 ram_sel, gpio_sel, ctl_sel;
    logic [4:0]           port_idx;
    logic [2:0]           reg_off;
    logic                 wr_flags, wr_mask, wr_ctrl, wr_count, wr_reload, wr_status;

    logic [PW-1:0]        sync1, sync2, prev;
    logic [NUM_PORTS-1:0] edge_flags, edge_mask, edge_hit;
    logic [2:0]           ctrl;
    logic [15:0]          count, reload;
    logic                 tflag;

    logic [PW-1:0]        io_out_n;
    logic [NUM_PORTS-1:0] flags_n, mask_n;
    logic [2:0]           ctrl_n;
    logic [15:0]          count_n, reload_n, rdata;
    logic                 tflag_n, tflag_set;

    assign ram_sel  = ~bus.addr[15];
    assign gpio_sel = (bus.addr[15:6] == 10'b10_0000_0000);
    assign ctl_sel  = (bus.addr[15:3] == 13'h1008);
    assign port_idx = bus.addr[5:1];
    assign reg_off  = bus.addr[2:0];

    assign ram_addr = bus.addr[14:0];
    assign ram_din  = bus.din;
    assign ram_we   = bus.we & ram_sel;

    assign wr_flags  = bus.we & ctl_sel & (reg_off == R_EDGE_FLAGS);
    assign wr_mask   = bus.we & ctl_sel & (reg_off == R_EDGE_MASK);
    assign wr_ctrl   = bus.we & ctl_sel & (reg_off == R_CTRL);
    assign wr_count  = bus.we & ctl_sel & (reg_off == R_COUNT);
    assign wr_reload = bus.we & ctl_sel & (reg_off == R_RELOAD);
    assign wr_status = bus.we & ctl_sel & (reg_off == R_STATUS);

    // Read mux; unmapped addresses and absent ports fall through to zero.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        rdata = '0;
        if (ram_sel) begin
            rdata = ram_dout;
        end else if (gpio_sel) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (port_idx == 5'(i))
                    rdata[IO_WIDTH-1:0] = bus.addr[0] ? sync2[i*IO_WIDTH +: IO_WIDTH]
                                                      : io_out[i*IO_WIDTH +: IO_WIDTH];
            end
        end else if (ctl_sel) begin
            case (reg_off)
                R_EDGE_FLAGS: rdata[NUM_PORTS-1:0] = edge_flags;
                R_EDGE_MASK:  rdata[NUM_PORTS-1:0] = edge_mask;
                R_CTRL:       rdata[2:0]           = ctrl;
                R_COUNT:      rdata                = count;
                R_RELOAD:     rdata                = reload;
                R_STATUS:     rdata[0]             = tflag;
                default:      ;
            endcase
        end
    end

    assign bus.dout = rdata;

    always_comb begin
        io_out_n = io_out;
        for (int i = 0; i < NUM_PORTS; i++) begin
            edge_hit[i] = |(sync2[i*IO_WIDTH +: IO_WIDTH] ^ prev[i*IO_WIDTH +: IO_WIDTH]);
            if (bus.we && gpio_sel && !bus.addr[0] && port_idx == 5'(i))
                io_out_n[i*IO_WIDTH +: IO_WIDTH] = bus.din[IO_WIDTH-1:0];
        end
        // Hardware set wins over a simultaneous write-1-to-clear.
        flags_n  = (edge_flags & ~(wr_flags ? bus.din[NUM_PORTS-1:0] : '0)) | edge_hit;
        mask_n   = wr_mask ? bus.din[NUM_PORTS-1:0] : edge_mask;
        reload_n = wr_reload ? bus.din : reload;

        count_n   = count;
        ctrl_n    = ctrl;
        tflag_set = 1'b0;
        if (ctrl[0]) begin
            if (count != 16'd0) begin
                count_n = count - 16'd1;
            end else begin
                tflag_set = 1'b1;
                if (ctrl[1]) count_n   = reload;
                else         ctrl_n[0] = 1'b0;
            end
        end
        // CPU writes override the timer's own update; the zero flag still sets.
        if (wr_count) count_n = bus.din;
        if (wr_ctrl)  ctrl_n  = bus.din[2:0];
        tflag_n = (tflag & ~(wr_status & bus.din[0])) | tflag_set;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            sync1      <= '0;
            sync2      <= '0;
            prev       <= '0;
            io_out     <= '0;
            edge_flags <= '0;
            edge_mask  <= '0;
            ctrl       <= '0;
            count      <= '0;
            reload     <= '0;
            tflag      <= 1'b0;
            irq        <= 1'b0;
        end else begin
            sync1      <= io_in;
            sync2      <= sync1;
            prev       <= sync2;
            io_out     <= io_out_n;
            edge_flags <= flags_n;
            edge_mask  <= mask_n;
            ctrl       <= ctrl_n;
            count      <= count_n;
            reload     <= reload_n;
            tflag      <= tflag_n;
            irq        <= (|(edge_flags & edge_mask)) | (tflag & ctrl[2]);
        end
    end
endmodule

// File: tb/tb_mmio_bus.sv
// Directed bench for mmio_bus: register map, RAM pass-through, edge flags,
// timer auto-reload/one-shot, CPU-write priority and mid-operation reset.
module tb_mmio_bus;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [14:0] ram_addr;
    logic [15:0] ram_din;
    logic        ram_we;
    logic [15:0] ram_dout = 16'h0000;
    logic [7:0]  io_in = 8'h00;
    logic [7:0]  io_out;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;

    mmio_bus_if bus ();

    mmio_bus #(.IO_WIDTH(4), .NUM_PORTS(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .ram_dout (ram_dout),
        .io_in    (io_in),
        .io_out   (io_out),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        bus.addr = a;
        bus.din  = d;
        bus.we   = 1'b1;
        @(posedge clk);
        #1;
        bus.we   = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] d);
        bus.addr = a;
        bus.we   = 1'b0;
        #1;
        d = bus.dout;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        vectors++; if (io_out !== 8'h00) begin miscompares++; $display("FAIL reset_io_out: got %h want 00", io_out); end
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b want 0", irq); end
        rd(16'h8042, d);
        vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL reset_ctrl: got %h want 0000", d); end
    endtask

    task automatic test_gpio_out();
        logic [15:0] d;
        wr(16'h8000, 16'h000A);
        wr(16'h8002, 16'h0005);
        vectors++; if (io_out !== 8'h5A) begin miscompares++; $display("FAIL io_out_5a: got %h want 5a", io_out); end
        rd(16'h8000, d);
        vectors++; if (d !== 16'h000A) begin miscompares++; $display("FAIL out0_read: got %h want 000a", d); end
        wr(16'h8004, 16'hFFFF);
        vectors++; if (io_out !== 8'h5A) begin miscompares++; $display("FAIL absent_port_write: got %h want 5a", io_out); end
        rd(16'h8004, d);
        vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL absent_port_read: got %h want 0000", d); end
        wr(16'h8002, 16'hFFF3);
        rd(16'h8002, d);
        vectors++; if (d !== 16'h0003) begin miscompares++; $display("FAIL out1_upper_zero: got %h want 0003", d); end
    endtask

    task automatic test_ram();
        logic [15:0] d;
        ram_dout = 16'hBEEF;
        bus.addr = 16'h0010; bus.din = 16'h1234; bus.we = 1'b1;
        #1;
        vectors++; if (ram_we !== 1'b1) begin miscompares++; $display("FAIL ram_we_low: got %b want 1", ram_we); end
        vectors++; if (ram_addr !== 15'h0010) begin miscompares++; $display("FAIL ram_addr: got %h want 0010", ram_addr); end
        vectors++; if (ram_din !== 16'h1234) begin miscompares++; $display("FAIL ram_din: got %h want 1234", ram_din); end
        vectors++; if (bus.dout !== 16'hBEEF) begin miscompares++; $display("FAIL ram_read: got %h want beef", bus.dout); end
        bus.addr = 16'h8000;
        #1;
        vectors++; if (ram_we !== 1'b0) begin miscompares++; $display("FAIL ram_we_high: got %b want 0", ram_we); end
        bus.we = 1'b0;
        rd(16'h8046, d);
        vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL unmapped_8046: got %h want 0000", d); end
        tick(1);
    endtask

    task automatic test_edge_flags();
        logic [15:0] d;
        wr(16'h8041, 16'h0002);
        io_in = 8'h30;
        tick(1);
        rd(16'h8003, d);
        vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL in1_after1: got %h want 0000", d); end
        tick(1);
        rd(16'h8003, d);
        vectors++; if (d !== 16'h0003) begin miscompares++; $display("FAIL in1_after2: got %h want 0003", d); end
        rd(16'h8040, d);
        vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL flags_after2: got %h want 0000", d); end
        tick(1);
        rd(16'h8040, d);
        vectors++; if (d !== 16'h0002) begin miscompares++; $display("FAIL flags_after3: got %h want 0002", d); end
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_after3: got %b want 0", irq); end
        tick(1);
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_after4: got %b want 1", irq); end
        wr(16'h8040, 16'h0002);
        rd(16'h8040, d);
        vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL flags_w1c: got %h want 0000", d); end
        tick(1);
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_after_w1c: got %b want 0", irq); end
        io_in = 8'h10;
        tick(2);
        wr(16'h8040, 16'h0002);
        rd(16'h8040, d);
        vectors++; if (d !== 16'h0002) begin miscompares++; $display("FAIL set_beats_w1c: got %h want 0002", d); end
        wr(16'h8040, 16'h0002);
        rd(16'h8040, d);
        vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL flags_final_clear: got %h want 0000", d); end
    endtask

    task automatic test_timer();
        logic [15:0] d;
        wr(16'h8044, 16'h0003);
        wr(16'h8043, 16'h0003);
        wr(16'h8042, 16'h0007);
        tick(3);
        rd(16'h8043, d);
        vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL count_zero: got %h want 0000", d); end
        rd(16'h8045, d);
        vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL tflag_early: got %h want 0000", d); end
        tick(1);
        rd(16'h8045, d);
        vectors++; if (d !== 16'h0001) begin miscompares++; $display("FAIL tflag_set1: got %h want 0001", d); end
        rd(16'h8043, d);
        vectors++; if (d !== 16'h0003) begin miscompares++; $display("FAIL count_reload: got %h want 0003", d); end
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL timer_irq_lag: got %b want 0", irq); end
        tick(1);
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL timer_irq: got %b want 1", irq); end
        wr(16'h8045, 16'h0001);
        tick(1);
        rd(16'h8045, d);
        vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL tflag_cleared: got %h want 0000", d); end
        tick(1);
        rd(16'h8045, d);
        vectors++; if (d !== 16'h0001) begin miscompares++; $display("FAIL tflag_period4: got %h want 0001", d); end
        wr(16'h8042, 16'h0005);
        tick(3);
        rd(16'h8042, d);
        vectors++; if (d !== 16'h0004) begin miscompares++; $display("FAIL oneshot_en_off: got %h want 0004", d); end
        tick(2);
        rd(16'h8043, d);
        vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL oneshot_hold: got %h want 0000", d); end
    endtask

    task automatic test_count_write_priority();
        logic [15:0] d;
        wr(16'h8042, 16'h0000);
        wr(16'h8043, 16'h0010);
        wr(16'h8042, 16'h0001);
        wr(16'h8043, 16'h0100);
        rd(16'h8043, d);
        vectors++; if (d !== 16'h0100) begin miscompares++; $display("FAIL count_write_wins: got %h want 0100", d); end
        tick(1);
        rd(16'h8043, d);
        vectors++; if (d !== 16'h00FF) begin miscompares++; $display("FAIL count_decrement: got %h want 00ff", d); end
        wr(16'h8042, 16'h0000);
        tick(3);
        rd(16'h8043, d);
        vectors++; if (d !== 16'h00FE) begin miscompares++; $display("FAIL count_frozen: got %h want 00fe", d); end
    endtask

    task automatic test_mid_reset();
        logic [15:0] d;
        wr(16'h8000, 16'h000F);
        wr(16'h8002, 16'h000F);
        wr(16'h8041, 16'h0003);
        wr(16'h8043, 16'h0050);
        wr(16'h8042, 16'h0007);
        io_in = 8'h11;
        tick(4);
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL pre_reset_irq: got %b want 1", irq); end
        vectors++; if (io_out !== 8'hFF) begin miscompares++; $display("FAIL pre_reset_io_out: got %h want ff", io_out); end
        io_in = 8'h00;
        rst_n = 1'b0;
        wr(16'h8000, 16'h0003);
        vectors++; if (io_out !== 8'h00) begin miscompares++; $display("FAIL reset_overrides_write: got %h want 00", io_out); end
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL mid_reset_irq: got %b want 0", irq); end
        rd(16'h8040, d);
        vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL mid_reset_flags: got %h want 0000", d); end
        rd(16'h8041, d);
        vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL mid_reset_mask: got %h want 0000", d); end
        rst_n = 1'b1;
        tick(3);
        rd(16'h8043, d);
        vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL timer_stopped: got %h want 0000", d); end
        rd(16'h8042, d);
        vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL ctrl_after_reset: got %h want 0000", d); end
    endtask

    initial begin
        bus.addr = 16'h0000;
        bus.din  = 16'h0000;
        bus.we   = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        test_reset();
        test_gpio_out();
        test_ram();
        test_edge_flags();
        test_timer();
        test_count_write_priority();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
